// File: rtl/serial_full_add.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flip-flop,
// LSB first, one bit per clock, result committed with a one-cycle done pulse.
module serial_full_add #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sh, b_sh;
    logic [WIDTH-2:0] s_sh;
    logic [WIDTH-1:0] s_wide;
    logic             c;
    logic [CNT_W-1:0] cnt;
    logic             sum_bit, carry_nxt, last_bit, load;

    // Full-adder cell on the current LSBs; s_wide is the sum register after this edge's shift.
    always_comb begin
        sum_bit   = a_sh[0] ^ b_sh[0] ^ c;
        carry_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
        last_bit  = (cnt == CNT_W'(WIDTH - 1));
        s_wide    = {sum_bit, s_sh};
    end

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_bit) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                load      = start;
                state_nxt = start ? ST_RUN : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            s_sh <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            s    <= '0;
            co   <= 1'b0;
        end else if (load) begin
            a_sh <= a;
            b_sh <= b;
            c    <= cin;
            cnt  <= '0;
        end else if (state == ST_RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            s_sh <= s_wide[WIDTH-1:1];
            c    <= carry_nxt;
            cnt  <= cnt + 1'b1;
            // Outputs only move at the final bit, so s/co hold the previous result during RUN.
            if (last_bit) begin
                s  <= s_wide;
                co <= carry_nxt;
            end
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule
